// File: rtl/formant_pkg.sv
// ---------------------------------------------------------------------------
// | Module  : formant_pkg                                                   |
// | Purpose : Shared defaults and FSM state type for the formant smoother.  |
// | Ports   : none (package)                                                |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

package formant_pkg;

  localparam int DEFAULT_BIT_WIDTH   = 32;
  localparam int DEFAULT_I           = 160;
  localparam int DEFAULT_FORMANTS    = 5;
  localparam int DEFAULT_ALPHA_SHIFT = 2;
  localparam int DEFAULT_MAX_JUMP    = 16;
  localparam int DEFAULT_HOLD_FRAMES = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PROCESS = 2'd1,
    ORDER   = 2'd2
  } smoother_state_e;

endpackage

`default_nettype wire

// File: rtl/formant_ema_update.sv
// ---------------------------------------------------------------------------
// | Module  : formant_ema_update                                            |
// | Purpose : Combinational single-formant tracker step: EMA, jump          |
// |           rejection with timed snap, invalid-value hold.                |
// | Ports   : x        raw formant bin                                      |
// |           s        current tracked estimate                             |
// |           cnt      consecutive over-jump count                          |
// |           primed   tracker already initialised                          |
// |           s_next   next tracked estimate                                |
// |           cnt_next next over-jump count                                 |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module formant_ema_update #(
  parameter int BIT_WIDTH   = 32,
  parameter int I           = 160,
  parameter int ALPHA_SHIFT = 2,
  parameter int MAX_JUMP    = 16,
  parameter int HOLD_FRAMES = 3,
  parameter int CNT_W       = 2
) (
  input  logic [BIT_WIDTH-1:0] x,
  input  logic [BIT_WIDTH-1:0] s,
  input  logic [CNT_W-1:0]     cnt,
  input  logic                 primed,
  output logic [BIT_WIDTH-1:0] s_next,
  output logic [CNT_W-1:0]     cnt_next
);

  localparam logic [BIT_WIDTH-1:0]        c_BINS     = BIT_WIDTH'(I);
  localparam logic signed [BIT_WIDTH:0]   c_MAX_JUMP = (BIT_WIDTH+1)'(MAX_JUMP);
  localparam logic [CNT_W:0]              c_HOLD     = (CNT_W+1)'(HOLD_FRAMES);

  logic signed [BIT_WIDTH:0] w_d;
  logic signed [BIT_WIDTH:0] w_abs;
  logic signed [BIT_WIDTH:0] w_step;
  logic signed [BIT_WIDTH:0] w_sum;
  logic [CNT_W:0]            w_cnt_inc;
  logic                      w_invalid;
  logic                      w_jump;

  // One extra bit keeps the difference of two unsigned values exact.
  assign w_d       = $signed({1'b0, x}) - $signed({1'b0, s});
  assign w_abs     = w_d[BIT_WIDTH] ? -w_d : w_d;
  // Arithmetic shift floors toward -inf, so a -4 step becomes -1.
  assign w_step    = w_d >>> ALPHA_SHIFT;
  assign w_sum     = $signed({1'b0, s}) + w_step;
  assign w_cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
  assign w_invalid = (x == '0) || (x >= c_BINS);
  assign w_jump    = w_abs > c_MAX_JUMP;

  always_comb begin
    s_next   = s;
    cnt_next = cnt;
    if (!primed) begin
      s_next   = x;
      cnt_next = '0;
    end else if (w_invalid) begin
      s_next   = s;
      cnt_next = cnt;
    end else if (w_jump) begin
      if (w_cnt_inc == c_HOLD) begin
        s_next   = x;
        cnt_next = '0;
      end else begin
        cnt_next = CNT_W'(w_cnt_inc);
      end
    end else begin
      // The sum always lies between s and x, so truncation is lossless.
      s_next   = BIT_WIDTH'(w_sum);
      cnt_next = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/formant_smoother.sv
// ---------------------------------------------------------------------------
// | Module  : formant_smoother                                              |
// | Purpose : Per-formant track smoother with monotonic output ordering.    |
// | Ports   : clk_in        clock                                           |
// |           rst_n_in      asynchronous active-low reset                   |
// |           formant_valid frame strobe for formant_freq                   |
// |           formant_freq  raw formant bins [0:FORMANTS-1]                 |
// |           track_clear   unprime tracker, zero counters, clear overrun   |
// |           smooth_valid  one-cycle strobe for smooth_freq                |
// |           smooth_freq   ordered tracked formants [0:FORMANTS-1]         |
// |           busy          frame in flight                                 |
// |           overrun       sticky dropped-frame flag                       |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module formant_smoother
  import formant_pkg::*;
#(
  parameter int BIT_WIDTH   = DEFAULT_BIT_WIDTH,
  parameter int I           = DEFAULT_I,
  parameter int FORMANTS    = DEFAULT_FORMANTS,
  parameter int ALPHA_SHIFT = DEFAULT_ALPHA_SHIFT,
  parameter int MAX_JUMP    = DEFAULT_MAX_JUMP,
  parameter int HOLD_FRAMES = DEFAULT_HOLD_FRAMES
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 formant_valid,
  input  logic [BIT_WIDTH-1:0] formant_freq [0:FORMANTS-1],
  input  logic                 track_clear,
  output logic                 smooth_valid,
  output logic [BIT_WIDTH-1:0] smooth_freq  [0:FORMANTS-1],
  output logic                 busy,
  output logic                 overrun
);

  // The counter never holds more than HOLD_FRAMES-1.
  localparam int CNT_W = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES);
  localparam int KW    = (FORMANTS < 2) ? 1 : $clog2(FORMANTS);
  localparam logic [KW-1:0] c_K_LAST = KW'(FORMANTS - 1);

  smoother_state_e      r_state;
  smoother_state_e      w_state_next;
  logic [KW-1:0]        r_k;
  logic                 r_primed;
  logic                 r_valid;
  logic                 r_overrun;
  logic [BIT_WIDTH-1:0] r_x   [0:FORMANTS-1];
  logic [BIT_WIDTH-1:0] r_s   [0:FORMANTS-1];
  logic [CNT_W-1:0]     r_cnt [0:FORMANTS-1];
  logic [BIT_WIDTH-1:0] r_out [0:FORMANTS-1];
  logic [BIT_WIDTH-1:0] w_ord [0:FORMANTS-1];
  logic [BIT_WIDTH-1:0] w_s_next;
  logic [CNT_W-1:0]     w_cnt_next;

  // Single update datapath shared across formants, indexed by r_k.
  formant_ema_update #(
    .BIT_WIDTH   (BIT_WIDTH),
    .I           (I),
    .ALPHA_SHIFT (ALPHA_SHIFT),
    .MAX_JUMP    (MAX_JUMP),
    .HOLD_FRAMES (HOLD_FRAMES),
    .CNT_W       (CNT_W)
  ) u_update (
    .x        (r_x[r_k]),
    .s        (r_s[r_k]),
    .cnt      (r_cnt[r_k]),
    .primed   (r_primed),
    .s_next   (w_s_next),
    .cnt_next (w_cnt_next)
  );

  // Running maximum; ordering only touches the outputs, never r_s.
  always_comb begin
    for (int k = 0; k < FORMANTS; k++) begin
      w_ord[k] = r_s[k];
    end
    for (int k = 1; k < FORMANTS; k++) begin
      if (w_ord[k-1] > r_s[k]) begin
        w_ord[k] = w_ord[k-1];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (track_clear) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (formant_valid) w_state_next = PROCESS;
        PROCESS: if (r_k == c_K_LAST) w_state_next = ORDER;
        ORDER:   w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_k       <= '0;
      r_primed  <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      for (int k = 0; k < FORMANTS; k++) begin
        r_x[k]   <= '0;
        r_s[k]   <= '0;
        r_cnt[k] <= '0;
        r_out[k] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      if (track_clear) begin
        // Clear beats a coincident frame; that frame is not an overrun.
        r_k       <= '0;
        r_primed  <= 1'b0;
        r_overrun <= 1'b0;
        for (int k = 0; k < FORMANTS; k++) begin
          r_cnt[k] <= '0;
        end
      end else begin
        if (formant_valid && (r_state != IDLE)) begin
          r_overrun <= 1'b1;
        end
        case (r_state)
          IDLE: begin
            if (formant_valid) begin
              r_k <= '0;
              for (int k = 0; k < FORMANTS; k++) begin
                r_x[k] <= formant_freq[k];
              end
            end
          end
          PROCESS: begin
            r_s[r_k]   <= w_s_next;
            r_cnt[r_k] <= w_cnt_next;
            r_k        <= r_k + KW'(1);
          end
          ORDER: begin
            r_out    <= w_ord;
            r_valid  <= 1'b1;
            r_primed <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign smooth_valid = r_valid;
  assign smooth_freq  = r_out;
  assign busy         = (r_state != IDLE);
  assign overrun      = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_formant_smoother.sv
// ---------------------------------------------------------------------------
// | Module  : tb_formant_smoother                                           |
// | Purpose : Self-checking bench for formant_smoother against a frame-level|
// |           reference model of the tracker.                               |
// | Ports   : none                                                          |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_formant_smoother;

  localparam int NF    = 5;
  localparam int NBINS = 160;

  logic        clk_in;
  logic        rst_n_in;
  logic        formant_valid;
  logic [31:0] formant_freq [0:NF-1];
  logic        track_clear;
  logic        smooth_valid;
  logic [31:0] smooth_freq  [0:NF-1];
  logic        busy;
  logic        overrun;

  int n_checks;
  int n_fail;

  // Reference tracker state
  int m_s   [NF];
  int m_cnt [NF];
  int m_out [NF];
  bit m_primed;
  bit m_ovr;
  int fr    [NF];

  formant_smoother dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .formant_valid (formant_valid),
    .formant_freq  (formant_freq),
    .track_clear   (track_clear),
    .smooth_valid  (smooth_valid),
    .smooth_freq   (smooth_freq),
    .busy          (busy),
    .overrun       (overrun)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_div4(input int d);
    if (d >= 0) return d / 4;
    return -((-d + 3) / 4);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NF; k++) begin
      m_s[k] = 0; m_cnt[k] = 0; m_out[k] = 0;
    end
    m_primed = 0;
    m_ovr    = 0;
  endtask

  task automatic model_clear();
    for (int k = 0; k < NF; k++) m_cnt[k] = 0;
    m_primed = 0;
    m_ovr    = 0;
  endtask

  task automatic model_frame();
    int d;
    for (int k = 0; k < NF; k++) begin
      if (!m_primed) begin
        m_s[k] = fr[k]; m_cnt[k] = 0;
      end else if (fr[k] == 0 || fr[k] >= NBINS) begin
        // invalid input: hold everything
      end else begin
        d = fr[k] - m_s[k];
        if ((d < 0 ? -d : d) > 16) begin
          if (m_cnt[k] + 1 == 3) begin
            m_s[k] = fr[k]; m_cnt[k] = 0;
          end else begin
            m_cnt[k] = m_cnt[k] + 1;
          end
        end else begin
          m_s[k]   = m_s[k] + floor_div4(d);
          m_cnt[k] = 0;
        end
      end
    end
    m_primed = 1;
    m_out[0] = m_s[0];
    for (int k = 1; k < NF; k++) m_out[k] = (m_s[k] > m_out[k-1]) ? m_s[k] : m_out[k-1];
  endtask

  task automatic check_outs(input string tag);
    for (int k = 0; k < NF; k++) check($sformatf("%s_out%0d", tag, k), smooth_freq[k], m_out[k]);
  endtask

  // Sends fr; inj > 0 raises formant_valid again inj cycles after capture.
  task automatic send_frame(input string tag, input int inj);
    int lat;
    @(negedge clk_in);
    formant_valid = 1'b1;
    for (int k = 0; k < NF; k++) formant_freq[k] = fr[k];
    @(posedge clk_in); #1;
    formant_valid = 1'b0;
    model_frame();
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk_in); #1;
      if (n == inj) begin
        formant_valid = 1'b1;
        for (int k = 0; k < NF; k++) formant_freq[k] = 32'd7 + 32'(k);
        m_ovr = 1;
      end else begin
        formant_valid = 1'b0;
      end
      if (smooth_valid) lat = n;
    end
    formant_valid = 1'b0;
    check({tag, "_latency"}, lat, 6);
    check_outs(tag);
    check({tag, "_overrun"}, {31'd0, overrun}, {31'd0, m_ovr});
    @(posedge clk_in); #1;
    check({tag, "_pulse_width"}, {31'd0, smooth_valid}, 0);
    check({tag, "_busy_after"}, {31'd0, busy}, 0);
  endtask

  task automatic do_clear();
    @(negedge clk_in); track_clear = 1'b1;
    @(negedge clk_in); track_clear = 1'b0;
    model_clear();
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk_in); #1;
      if (smooth_valid) pulses++;
    end
  endtask

  int pulses;
  int r;

  initial begin
    n_checks = 0; n_fail = 0;
    formant_valid = 1'b0; track_clear = 1'b0;
    for (int k = 0; k < NF; k++) formant_freq[k] = '0;
    model_reset();
    rst_n_in = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in); rst_n_in = 1'b1;
    #1;
    check("rst_valid", {31'd0, smooth_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    check_outs("rst");

    // First frame passes through; then floor-rounded EMA
    fr = '{10, 30, 50, 70, 90}; send_frame("t1", 0);
    fr = '{14, 30, 46, 70, 90}; send_frame("t2", 0);
    check("t2_floor0", smooth_freq[0], 11);
    check("t2_floor2", smooth_freq[2], 49);

    // Jump rejection then snap on the third over-jump frame
    fr = '{11, 60, 49, 70, 90}; send_frame("t3a", 0);
    fr = '{11, 60, 49, 70, 90}; send_frame("t3b", 0);
    check("t3b_held", smooth_freq[1], 30);
    fr = '{11, 60, 49, 70, 90}; send_frame("t3c", 0);
    check("t3c_snap", smooth_freq[1], 60);
    do_clear();
    fr = '{11, 30, 49, 70, 90}; send_frame("t3d", 0);
    fr = '{11, 60, 49, 70, 90}; send_frame("t3e", 0);
    fr = '{11, 31, 49, 70, 90}; send_frame("t3f", 0);
    fr = '{11, 60, 49, 70, 90}; send_frame("t3g", 0);
    check("t3g_cnt_reset", smooth_freq[1], 30);

    // Invalid values hold, then clear and ordering
    fr = '{11, 30, 0, 70, 90};   send_frame("t4a", 0);
    fr = '{11, 30, 200, 70, 90}; send_frame("t4b", 0);
    do_clear();
    fr = '{40, 35, 60, 80, 100}; send_frame("t4c", 0);
    check("t4c_order", smooth_freq[1], 40);
    fr = '{40, 35, 60, 80, 100}; send_frame("t4d", 0);
    check("t4d_order", smooth_freq[1], 40);

    // Overrun: second strobe while busy is dropped
    fr = '{45, 50, 65, 85, 110}; send_frame("t5", 2);
    check("t5_overrun_set", {31'd0, overrun}, 1);
    do_clear();
    #1 check("t5_overrun_clr", {31'd0, overrun}, 0);

    // Clear together with formant_valid: frame dropped, no overrun
    @(negedge clk_in);
    formant_valid = 1'b1; track_clear = 1'b1;
    for (int k = 0; k < NF; k++) formant_freq[k] = 32'd99;
    @(negedge clk_in);
    formant_valid = 1'b0; track_clear = 1'b0;
    model_clear();
    check("clrv_busy", {31'd0, busy}, 0);
    check("clrv_overrun", {31'd0, overrun}, 0);
    count_pulses(10, pulses);
    check("clrv_no_pulse", pulses, 0);

    // Clear while busy aborts the frame
    @(negedge clk_in);
    formant_valid = 1'b1;
    for (int k = 0; k < NF; k++) formant_freq[k] = 32'd120;
    @(negedge clk_in); formant_valid = 1'b0;
    @(negedge clk_in); track_clear = 1'b1;
    @(negedge clk_in); track_clear = 1'b0;
    model_clear();
    check("abort_busy", {31'd0, busy}, 0);
    count_pulses(10, pulses);
    check("abort_no_pulse", pulses, 0);
    check_outs("abort_hold");

    // Asynchronous reset in PROCESS
    @(negedge clk_in);
    formant_valid = 1'b1;
    for (int k = 0; k < NF; k++) formant_freq[k] = 32'd77;
    @(posedge clk_in); #1 formant_valid = 1'b0;
    @(posedge clk_in); @(posedge clk_in); #2;
    rst_n_in = 1'b0;
    #1;
    model_reset();
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_valid", {31'd0, smooth_valid}, 0);
    check_outs("arst");
    @(negedge clk_in); @(negedge clk_in); rst_n_in = 1'b1;
    count_pulses(10, pulses);
    check("arst_no_pulse", pulses, 0);
    fr = '{20, 25, 15, 140, 150}; send_frame("t6", 0);

    // Randomized frames around the current track
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 7) == 0) do_clear();
      for (int k = 0; k < NF; k++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0)      fr[k] = 0;
        else if (r == 1) fr[k] = NBINS + int'($urandom_range(0, 50));
        else if (r < 4)  fr[k] = m_s[k] + (($urandom_range(0, 1) != 0) ? 1 : -1) * int'($urandom_range(17, 60));
        else             fr[k] = m_s[k] + int'($urandom_range(0, 32)) - 16;
        if (r > 1 && fr[k] < 1)          fr[k] = 1;
        if (r > 1 && fr[k] > NBINS - 1)  fr[k] = NBINS - 1;
      end
      send_frame($sformatf("rnd%0d", f), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
